everloop_rx: RTL

Single-wire NRZ pulse-width decoder for the Everloop LED chain: the receive counterpart of the Everloop transmitter. It recovers 8-bit bytes (MSB first) from the `everloop_d` waveform by measuring each high pulse, detects the low-level latch/reset gap as end-of-frame, and presents bytes to the Wishbone side through a one-entry valid/ack holding register. It sits on the chain's return/DOUT pin for loopback self-test and for capturing frames from upstream controllers.

---
 rtl/everloop_pkg.sv | 24 ++
 rtl/everloop_rx_sync.sv | 29 ++
 rtl/everloop_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/everloop_pkg.sv
// Shared Everloop timing constants and the receiver state encoding.
package everloop_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_t;

    // Transmitter high widths (clk cycles) and bit period.
    localparam int EL_T0_SHORT = 60;
    localparam int EL_T0_LONG  = 80;
    localparam int EL_T1_SHORT = 120;
    localparam int EL_T1_LONG  = 160;
    localparam int EL_PERIOD   = 240;

    // Receiver decode defaults.
    localparam int EL_MIN_HIGH   = 30;
    localparam int EL_BIT_THRESH = 100;
    localparam int EL_MAX_HIGH   = 200;
    localparam int EL_RESET_GAP  = 4000;

endpackage

// File: rtl/everloop_rx_sync.sv
// Two-flop synchronizer for the Everloop line plus a previous-sample flop for edge detection.
module everloop_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/everloop_rx.sv
// Everloop pulse-width receiver: decodes MSB-first bytes from high-pulse widths,
// detects the low latch gap as end-of-frame, and holds one byte for the consumer.
module everloop_rx
    import everloop_pkg::*;
#(
    parameter int MIN_HIGH   = EL_MIN_HIGH,
    parameter int BIT_THRESH = EL_BIT_THRESH,
    parameter int MAX_HIGH   = EL_MAX_HIGH,
    parameter int RESET_GAP  = EL_RESET_GAP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        everloop_d,
    input  logic        ack,
    input  logic        clear_flags,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_end,
    output logic [15:0] byte_count,
    output logic        bit_error,
    output logic        overrun,
    output logic [1:0]  state_dbg
);

    localparam logic [15:0] GAP_LAST = 16'(RESET_GAP - 1);
    localparam logic [15:0] MAX_CNT  = 16'(MAX_HIGH);
    localparam logic [16:0] MIN_W    = 17'(MIN_HIGH);
    localparam logic [16:0] MAX_W    = 17'(MAX_HIGH);
    localparam logic [16:0] THRESH_W = 17'(BIT_THRESH);

    rx_state_t   state, state_nxt;
    logic        lvl, rise, fall;
    logic [15:0] cnt;
    logic [16:0] width;
    logic [7:0]  sreg;
    logic [2:0]  bit_cnt;
    logic        shift_en, new_bit, err, fe, clr_frame, drop_bits;
    logic        byte_done, ovr;
    logic [7:0]  byte_val;

    everloop_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (everloop_d),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    // cnt holds width-1 on the cycle the fall is seen.
    assign width     = {1'b0, cnt} + 17'd1;
    assign byte_done = shift_en && (bit_cnt == 3'd7);
    assign byte_val  = {sreg[6:0], new_bit};
    assign ovr       = byte_done && data_valid && !ack;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        new_bit   = 1'b0;
        err       = 1'b0;
        fe        = 1'b0;
        clr_frame = 1'b0;
        drop_bits = 1'b0;
        case (state)
            ST_SYNC: begin
                if (!lvl && cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    clr_frame = 1'b1;
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (width < MIN_W || width > MAX_W) begin
                        err       = 1'b1;
                        drop_bits = 1'b1;
                        state_nxt = ST_SYNC;
                    end else begin
                        shift_en  = 1'b1;
                        new_bit   = (width >= THRESH_W);
                        state_nxt = ST_LOW;
                    end
                end else if (cnt > MAX_CNT) begin
                    err       = 1'b1;
                    drop_bits = 1'b1;
                    state_nxt = ST_SYNC;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                end else if (cnt == GAP_LAST) begin
                    fe        = 1'b1;
                    err       = (bit_cnt != 3'd0);
                    drop_bits = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SYNC;
            cnt        <= 16'd0;
            sreg       <= 8'd0;
            bit_cnt    <= 3'd0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            byte_count <= 16'd0;
            bit_error  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_end <= fe;

            // In SYNC a high line holds the count at zero so only a true gap re-arms.
            if (rise || fall || (state == ST_SYNC && lvl)) cnt <= 16'd0;
            else if (cnt != 16'hFFFF)                      cnt <= cnt + 16'd1;

            if (clr_frame) begin
                bit_cnt    <= 3'd0;
                byte_count <= 16'd0;
            end else if (drop_bits) begin
                bit_cnt <= 3'd0;
                sreg    <= 8'd0;
            end else if (shift_en) begin
                sreg    <= byte_val;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done && byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;

            // A same-cycle ack frees the slot for the completing byte.
            if (byte_done) begin
                if (!data_valid || ack) begin
                    data_out   <= byte_val;
                    data_valid <= 1'b1;
                end
            end else if (ack) begin
                data_valid <= 1'b0;
            end

            bit_error <= err | (bit_error & ~clear_flags);
            overrun   <= ovr | (overrun & ~clear_flags);
        end
    end

endmodule
